// File: rtl/vending_controller_n.sv
// N-product quarter vending controller: per-product prices, saturating credit,
// explicit refund, coin rejection and quarter-at-a-time change return.
module vending_controller_n #(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned CREDIT_W     = 3,
  parameter int unsigned MAX_CREDIT   = 7,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = 12'b110_100_011_010
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    quarter_in,
  input  logic [NUM_PRODUCTS-1:0] select,
  input  logic                    refund_req,
  output logic [CREDIT_W-1:0]     credit,
  output logic [NUM_PRODUCTS-1:0] product,
  output logic                    quarter_out,
  output logic                    coin_reject,
  output logic                    busy
);

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE_C = CREDIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VEND,
    ST_CHANGE
  } state_e;

  state_e                  state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [NUM_PRODUCTS-1:0] product_q, product_d;
  logic                    quarter_out_q, quarter_out_d;
  logic                    coin_reject_q, coin_reject_d;
  logic                    busy_q, busy_d;
  logic [CREDIT_W-1:0]     sel_price;

  // Price of the selected product; only meaningful when select is one-hot.
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (select[i]) sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    product_d     = '0;
    coin_reject_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (quarter_in) begin
          if (credit_q < MAX_C) credit_d = credit_q + ONE_C;
          else                  coin_reject_d = 1'b1;
        end else if (refund_req) begin
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if ($onehot(select) && (credit_q >= sel_price)) begin
          state_d   = ST_VEND;
          credit_d  = credit_q - sel_price;
          product_d = select;
        end
      end
      ST_VEND: begin
        coin_reject_d = quarter_in;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_d = quarter_in;
        // Last quarter leaves with this edge; clamp guards against underflow.
        if (credit_q <= ONE_C) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end else begin
          credit_d = credit_q - ONE_C;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase

    busy_d        = (state_d != ST_IDLE);
    quarter_out_d = (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      product_q     <= '0;
      quarter_out_q <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      product_q     <= product_d;
      quarter_out_q <= quarter_out_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign product     = product_q;
  assign quarter_out = quarter_out_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_controller_n.sv
// Directed bench for vending_controller_n: default instance plus a
// two-product legacy-parameter instance.
module tb_vending_controller_n;

  logic       clk;
  logic       reset;
  logic       quarter_in;
  logic [3:0] select;
  logic       refund_req;
  logic [2:0] credit;
  logic [3:0] product;
  logic       quarter_out;
  logic       coin_reject;
  logic       busy;

  logic       b_quarter_in;
  logic [1:0] b_select;
  logic       b_refund_req;
  logic [1:0] b_credit;
  logic [1:0] b_product;
  logic       b_quarter_out;
  logic       b_coin_reject;
  logic       b_busy;

  int tests;
  int fails;

  vending_controller_n dut (
    .clk         (clk),
    .reset       (reset),
    .quarter_in  (quarter_in),
    .select      (select),
    .refund_req  (refund_req),
    .credit      (credit),
    .product     (product),
    .quarter_out (quarter_out),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  vending_controller_n #(
    .NUM_PRODUCTS (2),
    .CREDIT_W     (2),
    .MAX_CREDIT   (3),
    .PRICES       (4'b11_10)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .quarter_in  (b_quarter_in),
    .select      (b_select),
    .refund_req  (b_refund_req),
    .credit      (b_credit),
    .product     (b_product),
    .quarter_out (b_quarter_out),
    .coin_reject (b_coin_reject),
    .busy        (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin();
    quarter_in = 1'b1;
    tick();
    quarter_in = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".credit"}, 32'(credit), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".qout"}, 32'(quarter_out), 0);
    chk({tag, ".product"}, 32'(product), 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    quarter_in = 1'b0;
    select = '0;
    refund_req = 1'b0;
    b_quarter_in = 1'b0;
    b_select = '0;
    b_refund_req = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst.reject", 32'(coin_reject), 0);
    reset = 1'b1;
    tick();

    // Three coins, buy product0 (price 2), one quarter change
    coin(); chk("c1", 32'(credit), 1);
    coin(); chk("c2", 32'(credit), 2);
    coin(); chk("c3", 32'(credit), 3);
    select = 4'b0001;
    tick();
    select = '0;
    chk("v0.product", 32'(product), 32'b0001);
    chk("v0.credit", 32'(credit), 1);
    chk("v0.busy", 32'(busy), 1);
    chk("v0.qout", 32'(quarter_out), 0);
    tick();
    chk("v0.ch.qout", 32'(quarter_out), 1);
    chk("v0.ch.product", 32'(product), 0);
    chk("v0.ch.busy", 32'(busy), 1);
    tick();
    chk_idle("v0.end");

    // Same sequence, reset pulled low mid-change
    coin(); coin(); coin();
    select = 4'b0001;
    tick();
    select = '0;
    tick();
    chk("rmid.qout_before", 32'(quarter_out), 1);
    #2 reset = 1'b0;
    #1;
    chk_idle("rmid");
    chk("rmid.reject", 32'(coin_reject), 0);
    reset = 1'b1;
    tick();
    chk_idle("rmid.rel");

    // Exact credit for product3 (price 6)
    for (int i = 0; i < 6; i++) coin();
    chk("ex.credit6", 32'(credit), 6);
    select = 4'b1000;
    tick();
    select = '0;
    chk("ex.product", 32'(product), 32'b1000);
    chk("ex.busy", 32'(busy), 1);
    chk("ex.credit", 32'(credit), 0);
    tick();
    chk_idle("ex.end");

    // Insufficient credit for product2 (price 4)
    coin(); coin();
    select = 4'b0100;
    tick();
    select = '0;
    chk("ins.credit", 32'(credit), 2);
    chk("ins.product", 32'(product), 0);
    chk("ins.busy", 32'(busy), 0);

    // Coin beats select in the same cycle
    quarter_in = 1'b1;
    select = 4'b0001;
    tick();
    quarter_in = 1'b0;
    select = '0;
    chk("pri.credit", 32'(credit), 3);
    chk("pri.product", 32'(product), 0);
    chk("pri.busy", 32'(busy), 0);

    // Multi-hot select ignored
    select = 4'b0011;
    tick();
    select = '0;
    chk("multi.credit", 32'(credit), 3);
    chk("multi.product", 32'(product), 0);

    // Refund of 5 quarters
    coin(); coin();
    chk("rf.credit5", 32'(credit), 5);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rf.qout%0d", i), 32'(quarter_out), 1);
      chk($sformatf("rf.credit%0d", i), 32'(credit), 32'(5 - i));
      tick();
    end
    chk_idle("rf.end");

    // Refund with zero credit is a no-op
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    chk_idle("rf0");

    // Coin during change is rejected, change count unaffected
    coin(); coin(); coin();
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    chk("cc.qout0", 32'(quarter_out), 1);
    quarter_in = 1'b1;
    tick();
    quarter_in = 1'b0;
    chk("cc.reject", 32'(coin_reject), 1);
    chk("cc.credit1", 32'(credit), 2);
    chk("cc.qout1", 32'(quarter_out), 1);
    tick();
    chk("cc.reject_off", 32'(coin_reject), 0);
    chk("cc.credit2", 32'(credit), 1);
    chk("cc.qout2", 32'(quarter_out), 1);
    tick();
    chk_idle("cc.end");

    // Saturation at 7, eighth coin rejected
    for (int i = 1; i <= 7; i++) begin
      coin();
      chk($sformatf("sat.credit%0d", i), 32'(credit), 32'(i));
      chk($sformatf("sat.noreject%0d", i), 32'(coin_reject), 0);
    end
    coin();
    chk("sat.credit8", 32'(credit), 7);
    chk("sat.reject", 32'(coin_reject), 1);
    tick();
    chk("sat.reject_off", 32'(coin_reject), 0);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk_idle("sat.end");

    // Legacy parameterisation: 2 products, 2-bit credit, max 3
    for (int i = 1; i <= 3; i++) begin
      b_quarter_in = 1'b1;
      tick();
      b_quarter_in = 1'b0;
      chk($sformatf("b.credit%0d", i), 32'(b_credit), 32'(i));
    end
    b_quarter_in = 1'b1;
    tick();
    b_quarter_in = 1'b0;
    chk("b.sat", 32'(b_credit), 3);
    chk("b.reject", 32'(b_coin_reject), 1);
    b_select = 2'b01;
    tick();
    b_select = '0;
    chk("b.product", 32'(b_product), 32'b01);
    chk("b.vcredit", 32'(b_credit), 1);
    tick();
    chk("b.qout", 32'(b_quarter_out), 1);
    chk("b.busy", 32'(b_busy), 1);
    tick();
    chk("b.end.qout", 32'(b_quarter_out), 0);
    chk("b.end.credit", 32'(b_credit), 0);
    chk("b.end.busy", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vending_controller_n.md
# vending_controller_n

Parametrised successor to the two-product quarter-only vending controller. It supports N products with per-product prices, a configurable credit range, an explicit refund request, and coin rejection. Change is returned as multiple quarters, one per cycle. It sits between the coin/selection front-end and the dispense actuators, and all outputs are registered.

## Interface
Parameters:
- NUM_PRODUCTS, default 4: number of products and width of `select` / `product`.
- CREDIT_W, default 3: width of the credit register in quarters. It is also the width of each price field.
- MAX_CREDIT, default 7: maximum credit in quarters. Legal range is 1..2^CREDIT_W-1.
- PRICES, default 12'b110_100_011_010: packed prices in quarters. Product k's price is `PRICES[k*CREDIT_W +: CREDIT_W]`. The default prices are $0.50, $0.75, $1.00 and $1.50.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately; release is sampled on `clk`.
- `quarter_in`  in  1  a quarter was inserted this cycle (one-cycle pulse per coin).
- `select`  in  NUM_PRODUCTS  product selection, one bit per product.
- `refund_req`  in  1  return all current credit.
- `credit`  out  CREDIT_W  current credit in quarters.
- `product`  out  NUM_PRODUCTS  one-hot, one-cycle dispense pulse.
- `quarter_out`  out  1  one quarter dispensed this cycle.
- `coin_reject`  out  1  one-cycle pulse: the last inserted coin was not accepted and is routed back.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, VEND, CHANGE. Encoding is free.
- Reset state: IDLE. All outputs reset to 0: `credit`=0, `product`=0, `quarter_out`=0, `coin_reject`=0, `busy`=0.

IDLE, evaluated per edge in this priority order:
1. **`quarter_in`=1.**
   - If `credit` < MAX_CREDIT, then `credit`+1.
   - Otherwise `credit` is unchanged and `coin_reject` pulses.
   - `select` and `refund_req` are ignored in the same cycle.
2. **`refund_req`=1.**
   - If `credit` > 0, go to CHANGE.
   - If `credit` = 0, this is a no-op.
3. **Exactly one `select` bit k set, and `credit` ≥ PRICE[k].**
   - Go to VEND.
   - `credit` becomes `credit` - PRICE[k].
   - `product[k]` is registered high.
4. **Zero or multiple `select` bits set, or insufficient credit:** no change. Credit is held.

VEND (exactly 1 cycle):
- `product[k]`=1 and `busy`=1.
- Next state is CHANGE if `credit` > 0, otherwise IDLE.

CHANGE:
- `quarter_out`=1 every cycle in this state.
- `credit` decrements by 1 at each edge.
- Return to IDLE at the edge where `credit` goes 1→0.
- Result: remaining credit of C quarters produces exactly C consecutive `quarter_out` cycles.

While busy (VEND or CHANGE):
- `select` and `refund_req` are ignored.
- Any `quarter_in` is not credited; `coin_reject` pulses on the next cycle.

Arithmetic rules:
- `credit` never exceeds MAX_CREDIT and never underflows.
- All comparisons are unsigned, at CREDIT_W bits.

Reset mid-operation: when `reset` goes low, the FSM returns immediately to IDLE with `credit`=0. Any in-flight change is abandoned.

## Timing
- Coin credit latency: 1 cycle. With `quarter_in` at edge n, `credit` is updated after edge n.
- Vend latency: 1 cycle. With `select` sampled at edge n, `product[k]` is high in cycle n+1. `credit` already shows the post-price value in that cycle.
- First change quarter: in cycle n+2 after the select edge. Change is then contiguous, 1 quarter per cycle.
- Refund latency: with `refund_req` sampled at edge n, the first `quarter_out` is in cycle n+1.
- Pulse widths: `coin_reject` is 1 cycle per rejected coin. `product` is 1 cycle per vend.
- `busy` timing: `busy` rises with VEND or CHANGE entry and falls in the cycle IDLE is re-entered.
- Minimum turnaround from one vend to the next accepted input is 2 + C cycles, where C is the number of change quarters.

## Test plan
- **Reset mid-change.** Apply reset low, insert 3 quarters, select product0 (price 2). Then:
  - Expected: `credit` 1,2,3; then `product`=0001 with `credit`=1; then 1 cycle of `quarter_out`; IDLE with `credit`=0.
  - Repeat the sequence and pull `reset` low during CHANGE: all outputs are 0 immediately.
- **Exact and insufficient credit.**
  - Insert 6 quarters, select product3 (price 6) → `product`=1000, no `quarter_out`, `busy` for 1 cycle.
  - With 2 quarters, select product2 → ignored, `credit` stays 2.
- **Refund.** Insert 5 quarters, assert `refund_req` → 5 consecutive `quarter_out` cycles, `credit` 5→0, then IDLE.
- **Saturation.** Insert 8 quarters → `credit` saturates at 7, and `coin_reject` pulses once for the 8th coin.
- **Priority and simultaneity.**
  - `quarter_in` together with `select`=0001 at `credit`=2 → `credit`=3, no vend.
  - `select`=0011 → ignored.
  - `quarter_in` during CHANGE → `coin_reject` pulse, and the change count is unaffected.
- **Parameter override.** Set NUM_PRODUCTS=2, CREDIT_W=2, MAX_CREDIT=3, PRICES=4'b11_10.
  - Insert 3 quarters, select product0 → `product`=01, then 1 `quarter_out`.
  - This reproduces legacy $0.75-minus-$0.50 behaviour.
